// File: rtl/bf16_sum_acc.sv
// Streaming BF16 vector accumulator with a registered single-cycle adder.
// Optional macro ACC_ZERO_SKIP_EN: zero/denormal elements skip the adder (1 cycle each).
module fp_add_single_cycle #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 7,
  parameter int SIGN_WIDTH     = 1,
  parameter int FP_WIDTH       = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [FP_WIDTH-1:0] a_i,
  input  logic [FP_WIDTH-1:0] b_i,
  output logic [FP_WIDTH-1:0] sum_o
);
  localparam int E  = EXP_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = M + 4;
  localparam int SW = $clog2(W + 1);
  localparam int XT = FP_WIDTH - SIGN_WIDTH - 1;

  logic [FP_WIDTH-1:0] big, sml, res_d, sum_q;
  logic [E-1:0]        el, es, d;
  logic [M:0]          ml, ms;
  logic [W-1:0]        ms_ext, al, mask, n;
  logic [W:0]          sum;
  logic [SW-1:0]       p, sh;
  logic [E+1:0]        ex;
  logic [M+1:0]        mr;
  logic                sgn, up;

  always_comb begin
    big = (a_i[XT:0] >= b_i[XT:0]) ? a_i : b_i;
    sml = (a_i[XT:0] >= b_i[XT:0]) ? b_i : a_i;
    sgn = big[FP_WIDTH-1];
    el  = big[XT -: E];
    es  = sml[XT -: E];
    ml  = (el != '0) ? {1'b1, big[M-1:0]} : '0;
    ms  = (es != '0) ? {1'b1, sml[M-1:0]} : '0;
    d   = el - es;
    ms_ext = {ms, 3'b000};
    mask   = ~({W{1'b1}} << d);
    // Alignment keeps guard/round bits plus a sticky OR of everything shifted out.
    if (d >= E'(W)) begin
      al = {{(W-1){1'b0}}, |ms};
    end else begin
      al    = ms_ext >> d;
      al[0] = al[0] | (|(ms_ext & mask));
    end
    if (sgn ^ sml[FP_WIDTH-1]) sum = {1'b0, ml, 3'b000} - {1'b0, al};
    else                       sum = {1'b0, ml, 3'b000} + {1'b0, al};
    ex = {2'b00, el};
    p  = '0;
    for (int unsigned i = 0; i < W; i++) if (sum[i]) p = SW'(i);
    sh = SW'(W - 1) - p;
    if (sum[W]) begin
      n    = sum[W:1];
      n[0] = n[0] | sum[0];
      ex   = ex + 1'b1;
    end else begin
      n  = sum[W-1:0] << sh;
      ex = ex - {{(E+2-SW){1'b0}}, sh};
    end
    up = n[2] & (n[1] | n[0] | n[3]);
    mr = {1'b0, n[W-1:3]} + {{(M+1){1'b0}}, up};
    ex = ex + {{(E+1){1'b0}}, mr[M+1]};
    if (el == '1) begin
      res_d = big;
    end else if (sum == '0) begin
      res_d = '0;
    end else if (ex[E+1] || ex == '0) begin
      res_d = {sgn, {(FP_WIDTH-1){1'b0}}};
    end else if (ex[E:0] >= {1'b0, {E{1'b1}}}) begin
      res_d = {sgn, {E{1'b1}}, {M{1'b0}}};
    end else begin
      res_d = {sgn, ex[E-1:0], (mr[M+1] ? mr[M:1] : mr[M-1:0])};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) sum_q <= '0;
    else       sum_q <= res_d;
  end

  assign sum_o = sum_q;
endmodule

module bf16_sum_acc #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 7,
  parameter int SIGN_WIDTH     = 1,
  parameter int FP_WIDTH       = 16,
  parameter int MAX_LEN        = 1024,
  localparam int CNT_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FP_WIDTH-1:0] input_data,
  input  logic                input_data_valid,
  input  logic                input_data_last,
  output logic                input_data_ready,
  output logic [FP_WIDTH-1:0] output_data,
  output logic                output_data_valid,
  input  logic                output_data_ready,
  output logic [CNT_W-1:0]    output_count
);
  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [FP_WIDTH-1:0] acc_q, acc_d, out_q, out_d, add_out;
  logic [CNT_W-1:0]    cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_inc;
  logic                last_q, last_d, ovalid_q, ovalid_d;

  fp_add_single_cycle #(
    .EXP_WIDTH      (EXP_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH),
    .SIGN_WIDTH     (SIGN_WIDTH),
    .FP_WIDTH       (FP_WIDTH)
  ) u_add (
    .clk   (clk),
    .rstn  (~rst),
    .a_i   (acc_q),
    .b_i   (input_data),
    .sum_o (add_out)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    out_d    = out_q;
    ocnt_d   = ocnt_q;
    ovalid_d = ovalid_q;
    cnt_inc  = cnt_q + CNT_W'(1);
    case (state_q)
      ST_ACC: begin
        if (input_data_valid) begin
          cnt_d  = cnt_inc;
          last_d = input_data_last | (cnt_inc == CNT_W'(MAX_LEN));
`ifdef ACC_ZERO_SKIP_EN
          // Zero/denormal adds nothing: finish straight from the current accumulator.
          if (input_data[FP_WIDTH-SIGN_WIDTH-1 -: EXP_WIDTH] == '0) begin
            if (last_d) begin
              out_d    = acc_q;
              ocnt_d   = cnt_inc;
              ovalid_d = 1'b1;
              state_d  = ST_DONE;
            end
          end else
`endif
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        acc_d = add_out;
        if (last_q) begin
          out_d    = add_out;
          ocnt_d   = cnt_q;
          ovalid_d = 1'b1;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_DONE: begin
        if (output_data_ready) begin
          ovalid_d = 1'b0;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ACC;
      acc_q    <= '0;
      cnt_q    <= '0;
      last_q   <= 1'b0;
      out_q    <= '0;
      ocnt_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      out_q    <= out_d;
      ocnt_q   <= ocnt_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign input_data_ready  = (state_q == ST_ACC);
  assign output_data       = out_q;
  assign output_count      = ocnt_q;
  assign output_data_valid = ovalid_q;
endmodule

// File: tb/tb_bf16_sum_acc.sv
// Directed bench for bf16_sum_acc; follows ACC_ZERO_SKIP_EN when the build defines it.
module tb_bf16_sum_acc;
  logic        clk;
  logic        rst;
  logic [15:0] input_data;
  logic        input_data_valid;
  logic        input_data_last;
  logic        input_data_ready;
  logic [15:0] output_data;
  logic        output_data_valid;
  logic        output_data_ready;
  logic [10:0] output_count;

  int tests = 0;
  int fails = 0;

  bf16_sum_acc #(.MAX_LEN(1024)) dut (
    .clk               (clk),
    .rst               (rst),
    .input_data        (input_data),
    .input_data_valid  (input_data_valid),
    .input_data_last   (input_data_last),
    .input_data_ready  (input_data_ready),
    .output_data       (output_data),
    .output_data_valid (output_data_valid),
    .output_data_ready (output_data_ready),
    .output_count      (output_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the element until the DUT is ready, then lets one edge accept it.
  task automatic send(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    input_data = d;
    input_data_valid = 1'b1;
    input_data_last = l;
    while (input_data_ready !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    if (n >= 8) chk("send_timeout", 32'(n), 32'd0);
    step();
    input_data_valid = 1'b0;
    input_data_last = 1'b0;
    input_data = '0;
  endtask

  task automatic expect_sum(input string tag, input logic [15:0] d, input logic [10:0] c);
    chk({tag, "_valid"}, 32'(output_data_valid), 32'd1);
    chk({tag, "_data"}, 32'(output_data), 32'(d));
    chk({tag, "_count"}, 32'(output_count), 32'(c));
    chk({tag, "_inready"}, 32'(input_data_ready), 32'd0);
  endtask

  task automatic release_sum(input string tag);
    output_data_ready = 1'b1;
    step();
    output_data_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(output_data_valid), 32'd0);
    chk({tag, "_inready_back"}, 32'(input_data_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    input_data = '0;
    input_data_valid = 1'b0;
    input_data_last = 1'b0;
    output_data_ready = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    chk("rst_inready", 32'(input_data_ready), 32'd1);
    chk("rst_valid", 32'(output_data_valid), 32'd0);
    chk("rst_data", 32'(output_data), 32'd0);
    chk("rst_count", 32'(output_count), 32'd0);

    // A last flag without valid must not end anything.
    input_data_last = 1'b1;
    step();
    input_data_last = 1'b0;
    chk("stray_last_valid", 32'(output_data_valid), 32'd0);
    chk("stray_last_ready", 32'(input_data_ready), 32'd1);

    // 1.0 + 2.0 = 3.0, valid two cycles after the last accept
    send(16'h3F80, 1'b0);
    send(16'h4000, 1'b1);
    chk("t1_valid_T1", 32'(output_data_valid), 32'd0);
    step();
    expect_sum("t1", 16'h4040, 11'd2);
    release_sum("t1");

    // Four back-to-back 1.0 with valid held high: ready alternates 1,0
    input_data = 16'h3F80;
    input_data_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("t2_ready_toggle", 32'(input_data_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      input_data_last = (i == 6);
      step();
    end
    input_data_valid = 1'b0;
    input_data_last = 1'b0;
    chk("t2_ready_wait", 32'(input_data_ready), 32'd0);
    chk("t2_valid_T1", 32'(output_data_valid), 32'd0);
    step();
    expect_sum("t2", 16'h4080, 11'd4);
    release_sum("t2");

    // Single 0.5 with last, then backpressure for five cycles
    send(16'h3F00, 1'b1);
    step();
    expect_sum("t3", 16'h3F00, 11'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_sum("t4_hold", 16'h3F00, 11'd1);
    end
    release_sum("t4");

    // Reset mid-vector discards the partial sum and count
    send(16'h3F80, 1'b0);
    send(16'h3F80, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst_inready", 32'(input_data_ready), 32'd1);
    chk("t5_rst_count", 32'(output_count), 32'd0);
    send(16'h4000, 1'b1);
    step();
    expect_sum("t5", 16'h4000, 11'd1);
    release_sum("t5");

    // Leading zero element
    send(16'h0000, 1'b0);
`ifdef ACC_ZERO_SKIP_EN
    chk("t6_zero_ready", 32'(input_data_ready), 32'd1);
`else
    chk("t6_zero_ready", 32'(input_data_ready), 32'd0);
`endif
    send(16'h3F80, 1'b1);
    step();
    expect_sum("t6", 16'h3F80, 11'd2);
    release_sum("t6");

    // MAX_LEN elements with no last flag: 1.0 followed by 1023 zeros
    send(16'h3F80, 1'b0);
    for (int i = 0; i < 1023; i++) send(16'h0000, 1'b0);
`ifndef ACC_ZERO_SKIP_EN
    step();
`endif
    expect_sum("t7_maxlen", 16'h3F80, 11'd1024);
    release_sum("t7");
    send(16'h4000, 1'b1);
    step();
    expect_sum("t7_next", 16'h4000, 11'd1);
    release_sum("t7_next");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
